// File: rtl/dm_dump_pkg.sv
// dm_dump_pkg: shared FSM encoding and UART framing constants for the data-memory dump engine.
package dm_dump_pkg;
  localparam int FRAME_BITS = 10;
  localparam int BIT_IDX_W = $clog2(FRAME_BITS);
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD_HI,
    SEND_HI,
    LOAD_LO,
    SEND_LO,
    NEXT,
    FINISH
  } state_t;
endpackage

// File: rtl/dm_uart_dump_uart_tx.sv
// uart_tx: 8N1 transmitter, LSB first, idle high, done pulse in the last stop-bit cycle.
module uart_tx
  import dm_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  output logic       o_tx,
  output logic       o_done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(FRAME_BITS - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_DATA = BIT_IDX_W'(FRAME_BITS - 2);
  logic                 busy;
  logic [CW-1:0]        clk_cnt;
  logic [BIT_IDX_W-1:0] bit_idx;
  logic [7:0]           shift;
  logic                 bit_end;
  assign bit_end = busy && clk_cnt == LAST_CLK;
  assign o_done  = bit_end && bit_idx == LAST_BIT;
  // bit_idx 0 is the start bit, 1..8 the data bits, 9 the stop bit
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      busy    <= 1'b0;
      clk_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      o_tx    <= 1'b1;
    end else if (!busy) begin
      if (i_start) begin
        busy    <= 1'b1;
        clk_cnt <= '0;
        bit_idx <= '0;
        shift   <= i_byte;
        o_tx    <= 1'b0;
      end
    end else if (!bit_end) begin
      clk_cnt <= clk_cnt + 1'b1;
    end else if (o_done) begin
      busy    <= 1'b0;
      clk_cnt <= '0;
      bit_idx <= '0;
    end else begin
      clk_cnt <= '0;
      bit_idx <= bit_idx + 1'b1;
      o_tx    <= (bit_idx == LAST_DATA) ? 1'b1 : shift[0];
      shift   <= shift >> 1;
    end
  end
endmodule

// File: rtl/dm_uart_dump.sv
// dm_uart_dump: after a start pulse, reads data-memory words 0..DUMP_WORDS-1 and sends each high byte first over UART.
module dm_uart_dump
  import dm_dump_pkg::*;
#(
  parameter int DATA_LENGTH  = 16,
  parameter int ADDR_LENGTH  = 11,
  parameter int DUMP_WORDS   = 512,
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_start,
  output logic [ADDR_LENGTH-1:0] o_Addr,
  output logic                   o_Rd,
  input  logic [DATA_LENGTH-1:0] i_Data,
  output logic                   o_tx,
  output logic                   o_busy,
  output logic                   o_done
);
  localparam logic [ADDR_LENGTH-1:0] LAST_ADDR = ADDR_LENGTH'(DUMP_WORDS - 1);
  state_t                 state, next;
  logic [ADDR_LENGTH-1:0] addr;
  logic [DATA_LENGTH-1:0] word;
  logic                   tx_start, tx_done;
  logic [7:0]             tx_byte;
  always_ff @(posedge i_clock) begin
    if (i_reset) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = i_start ? FETCH : IDLE;
      FETCH:   next = LOAD_HI;
      LOAD_HI: next = SEND_HI;
      SEND_HI: next = tx_done ? LOAD_LO : SEND_HI;
      LOAD_LO: next = SEND_LO;
      SEND_LO: next = tx_done ? NEXT : SEND_LO;
      NEXT:    next = (addr == LAST_ADDR) ? FINISH : FETCH;
      FINISH:  next = IDLE;
    endcase
  end
  always_comb begin
    o_Rd     = state == FETCH;
    o_busy   = state != IDLE && state != FINISH;
    o_done   = state == FINISH;
    tx_start = state == LOAD_HI || state == LOAD_LO;
    tx_byte  = (state == LOAD_HI) ? word[15:8] : word[7:0];
  end
  // the counter stops at the last address, so it never wraps even when DUMP_WORDS fills the address space
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      addr <= '0;
      word <= '0;
    end else begin
      if (state == IDLE && i_start) addr <= '0;
      if (state == NEXT && addr != LAST_ADDR) addr <= addr + 1'b1;
      if (state == FETCH) word <= i_Data;
    end
  end
  assign o_Addr = addr;
  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_start(tx_start),
    .i_byte (tx_byte),
    .o_tx   (o_tx),
    .o_done (tx_done)
  );
endmodule
